// File: rtl/comparator_signed_4bit_if.sv
// Bit-level operand and result bundle for the registered signed 4-bit comparator.
// master drives operands and in_valid; slave returns flags and out_valid.
interface comparator_signed_4bit_if;
  logic in_valid;
  logic A3;
  logic A2;
  logic A1;
  logic A0;
  logic B3;
  logic B2;
  logic B1;
  logic B0;
  logic A_GREATER_B;
  logic A_LESS_B;
  logic A_EQUAL_B;
  logic out_valid;

  modport master (
    output in_valid,
    output A3, A2, A1, A0,
    output B3, B2, B1, B0,
    input  A_GREATER_B, A_LESS_B, A_EQUAL_B,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  A3, A2, A1, A0,
    input  B3, B2, B1, B0,
    output A_GREATER_B, A_LESS_B, A_EQUAL_B,
    output out_valid
  );
endinterface

// File: rtl/comparator_signed_4bit.sv
// Signed 4-bit compare with flags registered one clock after in_valid.
// Flags hold between samples; no backpressure, out_valid is a per-sample pulse.
module comparator_signed_4bit (
  input  logic                      clk,
  input  logic                      rst_n,
  comparator_signed_4bit_if.slave   bus
);

  logic [3:0] a_key;
  logic [3:0] b_key;
  logic       gt_nxt;
  logic       lt_nxt;
  logic       eq_nxt;

  // Flipping the sign bit maps -8..+7 onto 0..15, so an unsigned compare gives signed order.
  always_comb begin
    a_key  = {~bus.A3, bus.A2, bus.A1, bus.A0};
    b_key  = {~bus.B3, bus.B2, bus.B1, bus.B0};
    gt_nxt = (a_key > b_key);
    lt_nxt = (a_key < b_key);
    eq_nxt = (a_key == b_key);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.A_GREATER_B <= 1'b0;
      bus.A_LESS_B    <= 1'b0;
      bus.A_EQUAL_B   <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.A_GREATER_B <= gt_nxt;
        bus.A_LESS_B    <= lt_nxt;
        bus.A_EQUAL_B   <= eq_nxt;
      end
    end
  end

endmodule

// File: tb/tb_comparator_signed_4bit.sv
// Scoreboard bench: stimulus queues expected flags, a negedge monitor checks every cycle.
module tb_comparator_signed_4bit;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  typedef struct {
    logic [2:0] f;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  comparator_signed_4bit_if bus ();

  comparator_signed_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t       q[$];
  int         cyc;
  logic       rst_seen;
  logic [2:0] held;
  int         checks;
  int         failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc      = 0;
    rst_seen = 1'b0;
  end

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst_n;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got {vld,gt,lt,eq}=%b want=%b", name, cyc, act, want);
    end
  endtask

  // Monitor: reset clears everything, a due entry must appear with out_valid, otherwise flags hold.
  always @(negedge clk) begin
    logic [3:0] act;
    exp_t       e;
    act = {bus.out_valid, bus.A_GREATER_B, bus.A_LESS_B, bus.A_EQUAL_B};
    if (cyc > 0) begin
      if (!rst_seen) begin
        held = 3'b000;
        while (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
        chk("reset", act, 4'b0000);
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        e    = q.pop_front();
        held = e.f;
        chk("result", act, {1'b1, e.f});
      end else begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
          void'(q.pop_front());
          chk("missed", act, 4'b1111);
        end
        chk("hold", act, {1'b0, held});
      end
    end
  end

  task automatic drive(input logic rst, input logic vld, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] f);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    bus.in_valid = vld;
    {bus.A3, bus.A2, bus.A1, bus.A0} = a;
    {bus.B3, bus.B2, bus.B1, bus.B0} = b;
    if (rst && vld) begin
      e.f   = f;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
    int sa;
    int sb;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    if (sa > sb) return GT;
    if (sa < sb) return LT;
    return EQ;
  endfunction

  initial begin
    int budget;
    checks       = 0;
    failures     = 0;
    held         = 3'b000;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    {bus.A3, bus.A2, bus.A1, bus.A0} = 4'b0111;
    {bus.B3, bus.B2, bus.B1, bus.B0} = 4'b0000;

    // Reset held two edges with in_valid high, then release idle
    drive(1'b0, 1'b1, 4'b0111, 4'b0000, 3'b000);
    drive(1'b0, 1'b1, 4'b0111, 4'b0000, 3'b000);
    drive(1'b1, 1'b0, 4'b0111, 4'b0000, 3'b000);
    drive(1'b1, 1'b0, 4'b0000, 4'b0111, 3'b000);

    // Sign-differing, back-to-back
    drive(1'b1, 1'b1, 4'b0000, 4'b1000, GT);
    drive(1'b1, 1'b1, 4'b1001, 4'b0001, LT);
    drive(1'b1, 1'b1, 4'b0100, 4'b1100, GT);
    // Same sign
    drive(1'b1, 1'b1, 4'b1000, 4'b1111, LT);
    drive(1'b1, 1'b1, 4'b0111, 4'b0011, GT);
    drive(1'b1, 1'b1, 4'b0100, 4'b0010, GT);
    // Equality and boundaries
    drive(1'b1, 1'b1, 4'b1110, 4'b1110, EQ);
    drive(1'b1, 1'b1, 4'b1111, 4'b1111, EQ);
    drive(1'b1, 1'b1, 4'b1000, 4'b0111, LT);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, LT);

    // Hold, then mid-stream reset
    drive(1'b1, 1'b1, 4'b0111, 4'b1000, GT);
    drive(1'b1, 1'b0, 4'b1000, 4'b0111, 3'b000);
    drive(1'b1, 1'b0, 4'b1000, 4'b0111, 3'b000);
    drive(1'b0, 1'b0, 4'b1000, 4'b0111, 3'b000);
    drive(1'b1, 1'b0, 4'b1000, 4'b0111, 3'b000);

    // Reset on the edge right after a sample, then first sample afterwards
    drive(1'b1, 1'b1, 4'b0001, 4'b0010, LT);
    drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'b000);
    drive(1'b1, 1'b1, 4'b0011, 4'b0010, GT);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 3'b000);

    // Exhaustive, back-to-back
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = i[7:4];
      b = i[3:0];
      drive(1'b1, 1'b1, a, b, model(a, b));
    end
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 3'b000);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", {3'b000, q.size() != 0}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
